// File: rtl/cpu_defs.sv
// Shared definitions for the ALU control path: state encodings, instruction
// field constants, ALU operation codes and writeback source selects.
package cpu_defs;

  // Controller states; explicit encodings keep debug dumps stable.
  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WR_REG = 3'd5,
    ST_WR_IMM = 3'd6
  } state_e;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } instr_cls_e;

  // Opcode field ir[15:13].
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Op field ir[12:11].
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALU operation codes.
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Register-file writeback source selects.
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/alu_ctrl_fsm_instr_dec.sv
// Combinational instruction decoder: splits the 16-bit instruction into its
// register/shift fields, classifies it and sign-extends both immediates.
module instr_dec
  import cpu_defs::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       ir_i,
  output logic [2:0]        rn_o,
  output logic [2:0]        rd_o,
  output logic [2:0]        rm_o,
  output logic [1:0]        sh_o,
  output logic [1:0]        op_o,
  output instr_cls_e        cls_o,
  output logic              illegal_o,
  output logic [DATA_W-1:0] sximm8_o,
  output logic [DATA_W-1:0] sximm5_o
);

  logic [2:0] opcode_s;

  assign opcode_s  = ir_i[15:13];
  assign op_o      = ir_i[12:11];
  assign rn_o      = ir_i[10:8];
  assign rd_o      = ir_i[7:5];
  assign sh_o      = ir_i[4:3];
  assign rm_o      = ir_i[2:0];
  assign sximm8_o  = {{(DATA_W-8){ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o  = {{(DATA_W-5){ir_i[4]}}, ir_i[4:0]};
  assign illegal_o = (cls_o == CLS_ILLEGAL);

  // Map the opcode/op pair onto an instruction class; anything unlisted is illegal.
  always_comb begin
    cls_o = CLS_ILLEGAL;
    case (opcode_s)
      OPC_MOV: begin
        if (op_o == OP_MOV_IMM) begin
          cls_o = CLS_MOV_IMM;
        end else if (op_o == OP_MOV_REG) begin
          cls_o = CLS_MOV_REG;
        end else begin
          cls_o = CLS_ILLEGAL;
        end
      end
      OPC_ALU: begin
        case (op_o)
          OP_ADD:  cls_o = CLS_ADD;
          OP_CMP:  cls_o = CLS_CMP;
          OP_AND:  cls_o = CLS_AND;
          OP_MVN:  cls_o = CLS_MVN;
          default: cls_o = CLS_ILLEGAL;
        endcase
      end
      default: cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU controller: accepts an instruction on the start handshake,
// then sequences operand reads, execution and writeback. Every output is a
// register loaded alongside the state it belongs to, so the strobes are
// glitch-free and never depend combinationally on s or in.
module alu_ctrl_fsm
  import cpu_defs::*;
#(
  parameter int DATA_W = 16,
  parameter int IR_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic [IR_W-1:0]   in,
  output logic              w,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic              illegal
);

  state_e            state_q;
  logic [IR_W-1:0]   ir_q;
  logic [IR_W-1:0]   ir_d;
  logic              w_q, write_q, loada_q, loadb_q, loadc_q, loads_q;
  logic              asel_q, bsel_q, illegal_q;
  logic [2:0]        readnum_q, writenum_q;
  logic [1:0]        vsel_q, aluop_q, shift_q;
  logic [DATA_W-1:0] sximm8_q, sximm5_q;

  logic [2:0]        rn_s, rd_s, rm_s;
  logic [1:0]        sh_s, op_s;
  instr_cls_e        cls_s;
  logic              illegal_s;
  logic [DATA_W-1:0] sximm8_s, sximm5_s;

  // Instruction the next state will see: the incoming word on an accepting edge, else the held ir.
  always_comb begin
    ir_d = ir_q;
    if ((state_q == ST_WAIT) && s) begin
      ir_d = in;
    end else begin
      ir_d = ir_q;
    end
  end

  instr_dec #(.DATA_W(DATA_W)) u_dec (
    .ir_i      (ir_d),
    .rn_o      (rn_s),
    .rd_o      (rd_s),
    .rm_o      (rm_s),
    .sh_o      (sh_s),
    .op_o      (op_s),
    .cls_o     (cls_s),
    .illegal_o (illegal_s),
    .sximm8_o  (sximm8_s),
    .sximm5_o  (sximm5_s)
  );

  // State register, ir and registered Moore outputs for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_WAIT;
      ir_q       <= '0;
      sximm8_q   <= '0;
      sximm5_q   <= '0;
      shift_q    <= 2'b00;
      w_q        <= 1'b1;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      illegal_q  <= 1'b0;
      asel_q     <= 1'b0;
      bsel_q     <= 1'b0;
      vsel_q     <= VSEL_C;
      aluop_q    <= ALU_ADD;
      readnum_q  <= 3'd0;
      writenum_q <= 3'd0;
    end else begin
      // Strobes are single-cycle unless the entered state re-asserts them.
      w_q        <= 1'b0;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      illegal_q  <= 1'b0;
      asel_q     <= 1'b0;
      bsel_q     <= 1'b0;
      vsel_q     <= VSEL_C;
      aluop_q    <= ALU_ADD;
      readnum_q  <= 3'd0;
      writenum_q <= 3'd0;
      case (state_q)
        ST_WAIT: begin
          if (s) begin
            ir_q      <= ir_d;
            sximm8_q  <= sximm8_s;
            sximm5_q  <= sximm5_s;
            shift_q   <= sh_s;
            illegal_q <= illegal_s;
            state_q   <= ST_DECODE;
          end else begin
            w_q     <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_DECODE: begin
          case (cls_s)
            CLS_MOV_IMM: begin
              readnum_q  <= rn_s;
              writenum_q <= rn_s;
              vsel_q     <= VSEL_IMM8;
              write_q    <= 1'b1;
              state_q    <= ST_WR_IMM;
            end
            CLS_MOV_REG, CLS_MVN: begin
              readnum_q <= rm_s;
              loadb_q   <= 1'b1;
              state_q   <= ST_GET_B;
            end
            CLS_ADD, CLS_CMP, CLS_AND: begin
              readnum_q <= rn_s;
              loada_q   <= 1'b1;
              state_q   <= ST_GET_A;
            end
            default: begin
              w_q     <= 1'b1;
              state_q <= ST_WAIT;
            end
          endcase
        end
        ST_GET_A: begin
          readnum_q <= rm_s;
          loadb_q   <= 1'b1;
          state_q   <= ST_GET_B;
        end
        ST_GET_B: begin
          // MOV reg runs as 0 + shifted B, so A is forced to zero.
          if (cls_s == CLS_MOV_REG) begin
            aluop_q <= ALU_ADD;
            asel_q  <= 1'b1;
          end else begin
            aluop_q <= op_s;
            asel_q  <= 1'b0;
          end
          if (cls_s == CLS_CMP) begin
            loads_q <= 1'b1;
          end else begin
            loadc_q <= 1'b1;
          end
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cls_s == CLS_CMP) begin
            w_q     <= 1'b1;
            state_q <= ST_WAIT;
          end else begin
            writenum_q <= rd_s;
            vsel_q     <= VSEL_C;
            write_q    <= 1'b1;
            state_q    <= ST_WR_REG;
          end
        end
        ST_WR_REG, ST_WR_IMM: begin
          w_q     <= 1'b1;
          state_q <= ST_WAIT;
        end
        default: begin
          w_q     <= 1'b1;
          state_q <= ST_WAIT;
        end
      endcase
    end
  end

  assign w        = w_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign write    = write_q;
  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign loadc    = loadc_q;
  assign loads    = loads_q;
  assign asel     = asel_q;
  assign bsel     = bsel_q;
  assign vsel     = vsel_q;
  assign ALUop    = aluop_q;
  assign shift    = shift_q;
  assign sximm8   = sximm8_q;
  assign sximm5   = sximm5_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: directed and random instructions are
// compared cycle by cycle against a step-list model of each instruction.
module tb_alu_ctrl_fsm;

  localparam int DATA_W = 16;
  localparam int IR_W   = 16;

  // Model step kinds (one per busy cycle, then idle).
  localparam int P_DEC  = 0;
  localparam int P_IMMW = 1;
  localparam int P_RDA  = 2;
  localparam int P_RDB  = 3;
  localparam int P_EXE  = 4;
  localparam int P_WB   = 5;
  localparam int P_IDLE = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              s;
  logic [IR_W-1:0]   in;
  logic              w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
  logic [2:0]        readnum, writenum;
  logic [1:0]        vsel, ALUop, shift;
  logic [DATA_W-1:0] sximm8, sximm5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.DATA_W(DATA_W), .IR_W(IR_W)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(in), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift),
    .sximm8(sximm8), .sximm5(sximm5), .illegal(illegal)
  );

  // Layout: w write loada loadb loadc loads illegal asel bsel vsel ALUop readnum writenum
  function automatic logic [18:0] obs();
    return {w, write, loada, loadb, loadc, loads, illegal, asel, bsel, vsel, ALUop, readnum, writenum};
  endfunction

  // Sequence of work an instruction needs, from its semantics.
  function automatic void build_steps(input logic [15:0] i, output int st[$]);
    logic [2:0] opc;
    logic [1:0] op;
    bit is_imm, is_movr, is_alu;
    opc = i[15:13];
    op  = i[12:11];
    is_imm  = (opc == 3'b110) && (op == 2'b10);
    is_movr = (opc == 3'b110) && (op == 2'b00);
    is_alu  = (opc == 3'b101);
    st = {};
    st.push_back(P_DEC);
    if (is_imm) begin
      st.push_back(P_IMMW);
    end else if (is_movr || is_alu) begin
      if (is_alu && op != 2'b11) st.push_back(P_RDA);  // MVN needs only Rm
      st.push_back(P_RDB);
      st.push_back(P_EXE);
      if (!(is_alu && op == 2'b01)) st.push_back(P_WB);  // CMP only sets status
    end
  endfunction

  function automatic void expect_at(input logic [15:0] i, input int k,
                                    output logic [18:0] e, output logic [18:0] m);
    int st[$];
    int step;
    bit is_movr, is_cmp, ill;
    logic ew, ewr, ela, elb, elc, els, eil, eas;
    logic [1:0] evs, eal;
    logic [2:0] ern, ewn;
    bit mvs, mal, mrn, mwn;
    build_steps(i, st);
    is_movr = (i[15:13] == 3'b110) && (i[12:11] == 2'b00);
    is_cmp  = (i[15:13] == 3'b101) && (i[12:11] == 2'b01);
    ill     = (st.size() == 1);
    step = (k < st.size()) ? st[k] : P_IDLE;
    {ew, ewr, ela, elb, elc, els, eil, eas} = 8'b0;
    evs = 2'b00; eal = 2'b00; ern = 3'd0; ewn = 3'd0;
    {mvs, mal, mrn, mwn} = 4'b0;
    case (step)
      P_DEC:  eil = ill;
      P_IMMW: begin ewr = 1'b1; ern = i[10:8]; ewn = i[10:8]; evs = 2'b10; mvs = 1'b1; mrn = 1'b1; mwn = 1'b1; end
      P_RDA:  begin ela = 1'b1; ern = i[10:8]; mrn = 1'b1; end
      P_RDB:  begin elb = 1'b1; ern = i[2:0]; mrn = 1'b1; end
      P_EXE:  begin
        if (is_cmp) els = 1'b1; else elc = 1'b1;
        eas = is_movr;
        eal = is_movr ? 2'b00 : i[12:11];
        mal = 1'b1;
      end
      P_WB:   begin ewr = 1'b1; ewn = i[7:5]; evs = 2'b00; mvs = 1'b1; mwn = 1'b1; end
      default: ew = 1'b1;
    endcase
    e = {ew, ewr, ela, elb, elc, els, eil, eas, 1'b0, evs, eal, ern, ewn};
    m = {7'h7F, mal, mal, {2{mvs}}, {2{mal}}, {3{mrn}}, {3{mwn}}};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; s = 1'b0; in = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== {1'b1, 18'b0}) begin
      errors++; $display("FAIL reset_state outputs=%h want %h", obs(), {1'b1, 18'b0});
    end
    checks++;
    if ({sximm8, sximm5, shift} !== 34'b0) begin
      errors++; $display("FAIL reset_imm got %h/%h/%b want 0", sximm8, sximm5, shift);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== {1'b1, 18'b0}) begin
      errors++; $display("FAIL reset_release outputs=%h want %h", obs(), {1'b1, 18'b0});
    end
  endtask

  // Runs one instruction from a WAIT negedge and checks every cycle until WAIT again.
  task automatic test_instr(input logic [15:0] i, input bit noisy, input string tag);
    int st[$];
    int n;
    logic [18:0] e, m, o;
    logic signed [7:0]  b8;
    logic signed [4:0]  b5;
    logic signed [15:0] x8, x5;
    build_steps(i, st);
    n  = st.size();
    b8 = i[7:0];
    b5 = i[4:0];
    x8 = b8;
    x5 = b5;
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL %s ready w=%b want 1", tag, w);
    end
    s = 1'b1; in = i;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k < n && noisy) begin
        s = 1'($urandom_range(0, 1)); in = 16'($urandom);
      end else begin
        s = 1'b0;
      end
      o = obs();
      expect_at(i, k, e, m);
      checks++;
      if ((o & m) !== (e & m)) begin
        errors++; $display("FAIL %s cyc%0d outputs=%h want %h (mask %h)", tag, k, o, e, m);
      end
      checks++;
      if ({sximm8, sximm5, shift} !== {x8, x5, i[4:3]}) begin
        errors++; $display("FAIL %s imm cyc%0d got %h/%h/%b want %h/%h/%b",
                           tag, k, sximm8, sximm5, shift, x8, x5, i[4:3]);
      end
    end
  endtask

  task automatic test_directed();
    test_instr(16'hD007, 1'b0, "mov_imm_pos");
    test_instr(16'hD1FE, 1'b0, "mov_imm_neg");
    test_instr(16'hA140, 1'b0, "add");
    test_instr(16'hA900, 1'b0, "cmp");
    test_instr(16'hB868, 1'b0, "mvn");
    test_instr(16'h0000, 1'b0, "illegal_zero");
    test_instr(16'hC0A9, 1'b0, "mov_reg");
    test_instr(16'hB2E3, 1'b0, "and");
    test_instr(16'hC800, 1'b0, "illegal_mov01");
    test_instr(16'hD800, 1'b0, "illegal_mov11");
    test_instr(16'hA140, 1'b1, "add_noisy_s");
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [6] = '{16'hA140, 16'hD1FE, 16'h0000, 16'hB868, 16'hA900, 16'hC0A9};
    for (int j = 0; j < 6; j++) test_instr(seq[j], 1'b0, "b2b");
  endtask

  task automatic test_reset_mid_op();
    s = 1'b1; in = 16'hA140;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s = 1'b0;
    end
    checks++;
    if (loadc !== 1'b1) begin
      errors++; $display("FAIL midreset_in_exec loadc=%b want 1", loadc);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({w, write, loada, loadb, loadc, loads} !== 6'b100000) begin
      errors++; $display("FAIL midreset_async got %b want 100000", {w, write, loada, loadb, loadc, loads});
    end
    @(posedge clk); #1;
    checks++;
    if ({w, write, loadc} !== 3'b100) begin
      errors++; $display("FAIL midreset_hold got %b want 100", {w, write, loadc});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== {1'b1, 18'b0} || sximm8 !== 16'h0000) begin
      errors++; $display("FAIL midreset_after outputs=%h sximm8=%h want %h 0000", obs(), sximm8, {1'b1, 18'b0});
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int j = 0; j < 150; j++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r[15:13] = 3'b101;
        1: r[15:13] = 3'b110;
        2: r[15:13] = 3'b101;
        default: r = r;
      endcase
      test_instr(r, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
Multi-cycle controller that initiates every ALU operation in the simple RISC datapath. It accepts one 16-bit instruction per start/wait handshake and decodes it. It then sequences register-file reads into the A and B operand registers, drives ALUop, shift and the operand selects, and finally writes back the result or updates the status register. The register file, shifter, ALU and status/C registers sit downstream and are steered only by this block.

Parameters:
DATA_W, 16, datapath width; sets the width of the sximm8/sximm5 outputs.
IR_W, 16, instruction width; the field positions below are fixed for 16.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
s  input  1  start; sampled only in WAIT
in  input  IR_W  instruction; latched into internal ir when accepted
w  output  1  high only in WAIT (ready for a new instruction)
readnum  output  3  register-file read index
writenum  output  3  register-file write index
write  output  1  register-file write enable
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C (result) register
loads  output  1  load status (Z) register
asel  output  1  1 forces the ALU A input to 0
bsel  output  1  1 selects sximm5 for the ALU B input
vsel  output  2  writeback source: 00 C, 01 PC (unused), 10 sximm8, 11 mdata (unused)
ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
shift  output  2  ir[4:3], passed to the shifter
sximm8  output  DATA_W  ir[7:0] sign-extended
sximm5  output  DATA_W  ir[4:0] sign-extended
illegal  output  1  one-cycle pulse when an opcode/op combination is unsupported

Behaviour:
- ir fields: opcode ir[15:13], op ir[12:11], Rn ir[10:8], Rd ir[7:5], sh ir[4:3], Rm ir[2:0].
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
- Reset (async, any state): state=WAIT, ir=0, w=1, all loads/write/illegal=0, asel=bsel=0, vsel=00, ALUop=00, readnum=writenum=0.
- All outputs are Moore outputs, decoded from registered state plus ir. Nothing combinational runs from s or in.
- WAIT: w=1. If s=1 at an edge, latch in->ir and go to DECODE. s is ignored in all other states; in is not re-sampled.
- DECODE (no strobes asserted):
  - MOV imm -> WR_IMM
  - MOV reg or MVN -> GET_B
  - ADD/CMP/AND -> GET_A
  - any other combination -> WAIT with illegal=1 for that cycle
- WR_IMM: readnum=writenum=Rn, vsel=10, write=1 -> WAIT.
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> EXEC.
- EXEC: bsel=0, and ALUop is op for 101-class and 00 for MOV reg.
  - asel=1 for MOV reg, else 0.
  - CMP: loads=1, loadc=0 -> WAIT.
  - Others: loadc=1 -> WR_REG.
- WR_REG: writenum=Rd, vsel=00, write=1 -> WAIT.
- Latency, counted in edges from the accepting edge until w=1:
  - MOV imm: 3
  - MOV reg, MVN, CMP: 5
  - ADD, AND: 6
  - illegal: 2
- Back-to-back: s held high in WAIT starts the next instruction on the very edge WAIT is re-entered+1, with no extra idle cycle beyond WAIT.
- Mid-operation reset aborts immediately. No write or load may be asserted while reset_n=0.
- sximm8/sximm5 are pure functions of ir; they hold while ir holds.

Decomposition:
- Shared package/header cpu_defs holds:
  - state encodings (WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM)
  - opcode/op constants
  - ALUop codes
  - vsel codes
- Sub-module instr_dec, purely combinational:
  - inputs: ir
  - outputs: field extraction, instruction class, illegal flag, sximm8, sximm5
- alu_ctrl_fsm keeps the ir register, the state register and output decode.

Test Plan:
- reset_n=0 mid-EXEC of ADD -> same cycle w=1, loadc=0, write=0; after release, state=WAIT.
- s=1, in=16'hD007 (MOV R0,#7) -> WR_IMM cycle: writenum=0, vsel=10, write=1, sximm8=16'h0007; w=1 three edges after accept.
- in=16'hD1FE (MOV R1,#-2) -> sximm8=16'hFFFE, writenum=1, write=1 exactly one cycle.
- in=16'hA140 (ADD R2,R1,R0):
  - loada with readnum=1, then loadb with readnum=0
  - EXEC: ALUop=00, loadc=1
  - WR_REG: writenum=2, vsel=00
  - w=1 after 6 edges
- in=16'hA900 (CMP R1,R0) -> EXEC ALUop=01, loads=1, loadc=0, write never asserted; in=16'hB868 (MVN R3,R0,sh=01) -> no loada, shift=01, ALUop=11, writenum=3.
- in=16'h0000 -> illegal=1 for one cycle in DECODE, no strobes, w=1 after 2 edges; s toggled during a busy ADD is ignored and ir unchanged.
